// File: rtl/stereo_sample_scheduler_pkg.sv
// Shared types and helpers for the dual-ADC stereo sample scheduler.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    // Integer-truncated divider value for a given sample rate.
    function automatic int unsigned period(
        input int unsigned clock_freq,
        input int unsigned sample_rate
    );
        return clock_freq / sample_rate;
    endfunction

endpackage

// File: rtl/stereo_sample_scheduler_if.sv
// Stereo frame valid/ready bundle between the scheduler and its sink.
interface stereo_frame_if #(
    parameter int unsigned DATA_WIDTH = 12
);

    logic [DATA_WIDTH-1:0] frame_ldata;
    logic [DATA_WIDTH-1:0] frame_rdata;
    logic                  frame_valid;
    logic                  frame_ready;

    modport master (
        output frame_ldata,
        output frame_rdata,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_ldata,
        input  frame_rdata,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/stereo_sample_scheduler_rate_tick_gen.sv
// Sample-rate divider: one-cycle tick every PERIOD cycles while enabled.
module rate_tick_gen #(
    parameter int unsigned PERIOD = 1133
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Gated so that dropping enable kills a tick in the same cycle.
    assign tick = enable && (count == LAST);

endmodule

// File: rtl/stereo_sample_scheduler.sv
// Fires both ADC readers per sample tick and packs results into frames.
module stereo_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned SAMPLE_RATE    = 44100,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned DATA_WIDTH     = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_status,
    output logic                  ladc_start,
    input  logic [DATA_WIDTH-1:0] ladc_data,
    input  logic                  ladc_strb,
    output logic                  radc_start,
    input  logic [DATA_WIDTH-1:0] radc_data,
    input  logic                  radc_strb,
    stereo_frame_if.master        frame,
    output logic                  overrun,
    output logic                  timeout
);

    localparam int unsigned PERIOD = period(CLOCK_FREQ, SAMPLE_RATE);
    localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES + 2 >= PERIOD) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must satisfy 2 <= T < PERIOD-2");
    end

    sched_state_t state;
    sched_state_t state_next;

    logic                  tick;
    logic                  start;
    logic                  complete;
    logic                  abort;
    logic                  got_l;
    logic                  got_r;
    logic [WCW-1:0]        wcnt;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] out_l;
    logic [DATA_WIDTH-1:0] out_r;
    logic                  out_valid;
    logic                  frame_lost;
    logic                  tick_lost;

    rate_tick_gen #(
        .PERIOD(PERIOD)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_next = START;
                end
            end
            START: begin
                start      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (got_l && got_r) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wcnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture side: first strobe per channel wins, later ones are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            got_l  <= 1'b0;
            got_r  <= 1'b0;
            wcnt   <= '0;
            hold_l <= '0;
            hold_r <= '0;
        end else if (state == START) begin
            got_l <= 1'b0;
            got_r <= 1'b0;
            wcnt  <= '0;
        end else if (state == WAIT) begin
            wcnt <= wcnt + WCW'(1);
            if (ladc_strb && !got_l) begin
                hold_l <= ladc_data;
                got_l  <= 1'b1;
            end
            if (radc_strb && !got_r) begin
                hold_r <= radc_data;
                got_r  <= 1'b1;
            end
        end
    end

    assign frame_lost = complete && out_valid && !frame.frame_ready;
    assign tick_lost  = tick && (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else if (complete && !frame_lost) begin
            out_l     <= hold_l;
            out_r     <= hold_r;
            out_valid <= 1'b1;
        end else if (out_valid && frame.frame_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (tick_lost || frame_lost) begin
                overrun <= 1'b1;
            end else if (clear_status) begin
                overrun <= 1'b0;
            end
            if (abort) begin
                timeout <= 1'b1;
            end else if (clear_status) begin
                timeout <= 1'b0;
            end
        end
    end

    assign ladc_start        = start;
    assign radc_start        = start;
    assign frame.frame_ldata = out_l;
    assign frame.frame_rdata = out_r;
    assign frame.frame_valid = out_valid;

endmodule

// File: tb/tb_stereo_sample_scheduler.sv
// Directed steps with randomized conversions checked against a timing model.
module tb_stereo_sample_scheduler;

    localparam int DW  = 12;
    localparam int TMO = 6;
    localparam int PER = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear_status;
    logic          ladc_start;
    logic          radc_start;
    logic          ladc_strb;
    logic          radc_strb;
    logic [DW-1:0] ladc_data;
    logic [DW-1:0] radc_data;
    logic          overrun;
    logic          timeout;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            xfers = 0;
    logic [DW-1:0] xl = '0;
    logic [DW-1:0] xr = '0;

    stereo_frame_if #(.DATA_WIDTH(DW)) fif ();

    stereo_sample_scheduler #(
        .CLOCK_FREQ    (1000),
        .SAMPLE_RATE   (100),
        .TIMEOUT_CYCLES(TMO),
        .DATA_WIDTH    (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear_status(clear_status),
        .ladc_start  (ladc_start),
        .ladc_data   (ladc_data),
        .ladc_strb   (ladc_strb),
        .radc_start  (radc_start),
        .radc_data   (radc_data),
        .radc_strb   (radc_strb),
        .frame       (fif),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    // Sink side: record every accepted frame.
    always @(negedge clock) begin
        if (fif.frame_valid === 1'b1 && fif.frame_ready === 1'b1) begin
            xfers <= xfers + 1;
            xl    <= fif.frame_ldata;
            xr    <= fif.frame_rdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int ref_cyc, input int gap);
        int n;
        n = 0;
        while (ladc_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("start_seen", ladc_start, 1);
        check("start_pair", radc_start, 1);
        if (gap > 0) check("start_gap", cyc - ref_cyc, gap);
    endtask

    // Called in the start cycle; delay 0 means that channel never strobes.
    task automatic conv(input int dl, input logic [DW-1:0] vl,
                        input int dr, input logic [DW-1:0] vr,
                        input bit dup, input bit chk, input int rdy_k);
        int m;
        int vcnt;
        int scnt;
        bit done;
        done = (dl > 0) && (dr > 0);
        m    = (dl > dr) ? dl : dr;
        vcnt = 0;
        scnt = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            ladc_strb = (k == dl) || (dup && k == dl + 1);
            if (k == dl) ladc_data = vl;
            else if (ladc_strb) ladc_data = 12'h555;
            else ladc_data = DW'($urandom);
            radc_strb = (k == dr);
            radc_data = (k == dr) ? vr : DW'($urandom);
            if (rdy_k >= 0) fif.frame_ready = (k == rdy_k);
            scnt += int'(ladc_start);
            vcnt += int'(fif.frame_valid);
            if (chk && done) begin
                if (k == m + 1 && rdy_k < 0)
                    check("pre_valid", fif.frame_valid, 0);
                if (k == m + 2) begin
                    check("frame_valid", fif.frame_valid, 1);
                    check("frame_ldata", fif.frame_ldata, vl);
                    check("frame_rdata", fif.frame_rdata, vr);
                end
                if (k == m + 3 && rdy_k < 0)
                    check("valid_one_cycle", fif.frame_valid, 0);
            end
            if (chk && !done) begin
                if (k == TMO) check("timeout_early", timeout, 0);
                if (k == TMO + 1) check("timeout_set", timeout, 1);
            end
        end
        ladc_strb = 1'b0;
        radc_strb = 1'b0;
        check("no_extra_start", scnt, 0);
        if (chk && !done) check("timeout_no_frame", vcnt, 0);
    endtask

    initial begin
        int c, c2, e, r, x0, nfr, dl, dr, v, s;
        logic [DW-1:0] al, ar, bl, br;

        reset           = 1'b1;
        enable          = 1'b0;
        clear_status    = 1'b0;
        ladc_strb       = 1'b0;
        radc_strb       = 1'b0;
        ladc_data       = '0;
        radc_data       = '0;
        fif.frame_ready = 1'b1;
        repeat (3) step();
        check("rst_lstart", ladc_start, 0);
        check("rst_rstart", radc_start, 0);
        check("rst_valid", fif.frame_valid, 0);
        check("rst_ldata", fif.frame_ldata, 0);
        check("rst_rdata", fif.frame_rdata, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);

        reset = 1'b0;
        step();
        enable = 1'b1;
        e = cyc;
        wait_start(e, PER);

        // Nominal frame
        c = cyc;
        conv(3, 12'h123, 4, 12'hABC, 1'b0, 1'b1, -1);
        wait_start(c, PER);
        check("nom_overrun", overrun, 0);
        check("nom_timeout", timeout, 0);
        nfr = 1;

        // Randomized conversions
        repeat (6) begin
            c  = cyc;
            dl = $urandom_range(1, TMO - 1);
            dr = $urandom_range(1, TMO - 1);
            conv(dl, DW'($urandom), dr, DW'($urandom), 1'b0, 1'b1, -1);
            wait_start(c, PER);
            nfr++;
        end
        check("xfer_count", xfers, nfr);

        // Coincident strobes with a duplicate left strobe
        c = cyc;
        conv(2, 12'hFFF, 2, 12'h000, 1'b1, 1'b1, -1);
        wait_start(c, PER);
        check("coinc_xl", xl, 12'hFFF);
        check("coinc_xr", xr, 12'h000);

        // Timeout, then clear
        c = cyc;
        conv(2, DW'($urandom), 0, '0, 1'b0, 1'b1, -1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check("timeout_clr", timeout, 0);
        check("timeout_ovr", overrun, 0);
        wait_start(c, PER);
        c = cyc;
        conv(4, 12'h2A5, 1, 12'h5A2, 1'b0, 1'b1, -1);
        wait_start(c, PER);

        // Backpressure across two conversions
        c = cyc;
        fif.frame_ready = 1'b0;
        al = DW'($urandom);
        ar = DW'($urandom);
        bl = ~al;
        br = ~ar;
        conv(2, al, 3, ar, 1'b0, 1'b0, -1);
        check("bp_valid_a", fif.frame_valid, 1);
        check("bp_ldata_a", fif.frame_ldata, al);
        check("bp_rdata_a", fif.frame_rdata, ar);
        x0 = xfers;
        wait_start(c, PER);
        c2 = cyc;
        conv(1, bl, 2, br, 1'b0, 1'b0, -1);
        check("bp_hold_l", fif.frame_ldata, al);
        check("bp_hold_r", fif.frame_rdata, ar);
        check("bp_hold_v", fif.frame_valid, 1);
        check("bp_overrun", overrun, 1);
        check("bp_no_xfer", xfers, x0);
        fif.frame_ready = 1'b1;
        step();
        check("bp_drain_v", fif.frame_valid, 0);
        check("bp_one_xfer", xfers, x0 + 1);
        check("bp_xfer_l", xl, al);
        check("bp_xfer_r", xr, ar);
        clear_status = 1'b1;
        wait_start(c2, PER);
        clear_status = 1'b0;
        check("bp_ovr_clr", overrun, 0);

        // Transfer and load in the same cycle
        c = cyc;
        fif.frame_ready = 1'b0;
        dl = $urandom_range(1, TMO - 1);
        dr = $urandom_range(1, TMO - 1);
        conv(dl, al, dr, ar, 1'b0, 1'b0, -1);
        check("sim_valid_a", fif.frame_valid, 1);
        x0 = xfers;
        wait_start(c, PER);
        c = cyc;
        conv(2, 12'h3C3, 1, 12'hC3C, 1'b0, 1'b1, 3);
        check("sim_overrun", overrun, 0);
        check("sim_xfer_a", xfers, x0 + 1);
        check("sim_xfer_al", xl, al);
        check("sim_hold_b", fif.frame_valid, 1);
        fif.frame_ready = 1'b1;
        step();
        check("sim_xfer_b", xfers, x0 + 2);
        check("sim_xfer_bl", xl, 12'h3C3);
        wait_start(c, PER);

        // Asynchronous reset mid-WAIT
        step();
        ladc_strb = 1'b1;
        ladc_data = 12'h7E1;
        step();
        ladc_strb = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", fif.frame_valid, 0);
        check("arst_ldata", fif.frame_ldata, 0);
        check("arst_rdata", fif.frame_rdata, 0);
        check("arst_start", ladc_start, 0);
        check("arst_flags", {overrun, timeout}, 0);
        step();
        step();
        reset     = 1'b0;
        r         = cyc;
        radc_strb = 1'b1;
        radc_data = 12'h1E7;
        v = 0;
        s = 0;
        repeat (9) begin
            step();
            radc_strb = 1'b0;
            v += int'(fif.frame_valid);
            s += int'(ladc_start);
        end
        check("arst_no_frame", v, 0);
        check("arst_no_start", s, 0);
        wait_start(r, PER);

        // Enable drop on the tick cycle, then re-enable
        c = cyc;
        conv(1, 12'h0F0, 5, 12'hF0F, 1'b0, 1'b1, -1);
        step();
        enable = 1'b0;
        s = 0;
        repeat (30) begin
            step();
            s += int'(ladc_start);
        end
        check("dis_no_start", s, 0);
        enable = 1'b1;
        e = cyc;
        wait_start(e, PER);
        c = cyc;
        conv(5, DW'($urandom), 4, DW'($urandom), 1'b0, 1'b1, -1);
        check("end_flags", {overrun, timeout}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
